// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin 16:1 mux arbiter.
// Optional tenure limit in the top level is enabled by defining ARB_TIMEOUT_EN.
package arb_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [N_REQ-1:0] sel2onehot(input sel_t s);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotate-priority encoder: first requester at or after ptr (cyclic), optionally
// ignoring one index. Rotates req so ptr lands at bit 0, encodes, adds ptr back.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  input  logic             excl_en,
  input  sel_t             excl_idx,
  output logic             found,
  output sel_t             idx
);

  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] rot;
  sel_t             off;
  logic             hit;

  always_comb begin
    masked = req;
    if (excl_en) begin
      masked[excl_idx] = 1'b0;
    end
  end

  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rot[i] = masked[sel_t'(ptr + sel_t'(i))];
    end
  end

  always_comb begin
    off = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rot[i] && !hit) begin
        off = sel_t'(i);
        hit = 1'b1;
      end
    end
  end

  assign found = |rot;
  assign idx   = sel_t'(ptr + off);

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of a shared 16:1 mux.
// Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD cycles of contended tenure.
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output sel_t             sel,
  output logic             busy
);

  if (MAX_HOLD < 1) begin : g_max_hold_chk
    $error("MAX_HOLD must be >= 1");
  end

  arb_state_t       state_q, state_d;
  sel_t             ptr_q, ptr_d;
  sel_t             sel_q, sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;

  logic owner_req;
  logic force_rot;
  logic load;
  sel_t pick_ptr;
  logic pick_found;
  sel_t pick_idx;

  assign owner_req = req[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t HOLD_LIM = cnt_t'(MAX_HOLD - 1);

  cnt_t cnt_q, cnt_d;
  logic others_req;

  assign others_req = |(req & ~grant_q);
  assign force_rot  = (state_q == GRANT) && (cnt_q == HOLD_LIM) && owner_req && others_req;

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != GRANT || load) begin
      cnt_d = '0;
    end else if (cnt_q != HOLD_LIM) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign force_rot = 1'b0;
`endif

  // While busy, the search always starts just past the current owner so the
  // releasing owner ends up with lowest priority.
  assign pick_ptr = (state_q == GRANT) ? sel_t'(sel_q + sel_t'(1)) : ptr_q;

  rr_pick u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .excl_en  (force_rot),
    .excl_idx (sel_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          grant_d = sel2onehot(pick_idx);
          sel_d   = pick_idx;
          load    = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req || force_rot) begin
          ptr_d = pick_ptr;
          if (pick_found) begin
            grant_d = sel2onehot(pick_idx);
            sel_d   = pick_idx;
            load    = 1'b1;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: cycle-level reference model plus
// directed literal checks; builds with or without ARB_TIMEOUT_EN.
module tb_rr_mux_arbiter;

  localparam int MH = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  sel;
  logic        busy;

  int errors = 0;
  int checks = 0;

  rr_mux_arbiter #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant),
    .sel   (sel),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_owner = -1;
  int          m_ptr   = 0;
  int          m_cnt   = 0;
  int          m_sel   = 0;
  logic [15:0] m_req   = '0;

  function automatic int pick(input logic [15:0] r, input int p, input int excl);
    for (int k = 0; k < 16; k++) begin
      int j;
      j = (p + k) % 16;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_cnt   <= 0;
      m_sel   <= 0;
    end else begin
      int o, p, c, s, j;
      bit rot;
      o = m_owner; p = m_ptr; c = m_cnt; s = m_sel;
      if (o < 0) begin
        j = pick(req, p, -1);
        if (j >= 0) begin o = j; s = j; c = 0; end
      end else begin
        rot = TO && (c == MH - 1) && req[o] && ((req & ~(16'h1 << o)) != 0);
        if (req[o] && !rot) begin
          c = (c + 1 > MH - 1) ? MH - 1 : c + 1;
        end else begin
          p = (o + 1) % 16;
          j = pick(req, p, rot ? o : -1);
          if (j >= 0) begin o = j; s = j; c = 0; end
          else        begin o = -1; c = 0; end
        end
      end
      m_owner <= o; m_ptr <= p; m_cnt <= c; m_sel <= s;
      m_req   <= req;
    end
  end

  // ---------------- per-cycle compare + starvation tracking ----------------
  logic [15:0] prev_grant = '0;
  int          waits[16];
  int          max_wait = 0;

  initial foreach (waits[i]) waits[i] = 0;

  always @(negedge clk) begin
    logic [15:0] eg;
    eg = (m_owner < 0) ? 16'h0 : (16'h1 << m_owner);
    chk("model_grant", {16'h0, grant}, {16'h0, eg});
    chk("model_busy",  {31'h0, busy},  {31'h0, (m_owner >= 0)});
    chk("model_sel",   {28'h0, sel},   m_sel);
    if (grant != prev_grant && grant != 16'h0) begin
      for (int i = 0; i < 16; i++) begin
        if (grant[i])      waits[i] = 0;
        else if (m_req[i]) waits[i] = waits[i] + 1;
        else               waits[i] = 0;
        if (waits[i] > max_wait) max_wait = waits[i];
      end
    end
    prev_grant = grant;
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [15:0] v);
    req = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
  endtask

  task automatic chk_out(input string name, input logic [15:0] eg, input logic [3:0] es, input logic eb);
    chk({name, "_grant"}, {16'h0, grant}, {16'h0, eg});
    chk({name, "_sel"},   {28'h0, sel},   {28'h0, es});
    chk({name, "_busy"},  {31'h0, busy},  {31'h0, eb});
  endtask

  initial begin
    logic [15:0] r;
    reset = 1'b0;
    req   = '0;
    #12 reset = 1'b1;

    // idle after reset
    for (int i = 0; i < 5; i++) step(16'h0000);
    chk_out("idle", 16'h0000, 4'd0, 1'b0);

    // single requester, then release keeps sel
    step(16'h0020);
    chk_out("single", 16'h0020, 4'd5, 1'b1);
    step(16'h0000);
    chk_out("single_rel", 16'h0000, 4'd5, 1'b0);

    // async reset mid-grant
    step(16'h0100);
    chk_out("pre_rst", 16'h0100, 4'd8, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk_out("async_rst", 16'h0000, 4'd0, 1'b0);
    #1 reset = 1'b1;

    // round-robin wrap between 0 and 15, no bubbles
    pulse_reset();
    step(16'h8001); chk_out("rr0", 16'h0001, 4'd0, 1'b1);
    step(16'h8001);
    step(16'h8000); chk_out("rr1", 16'h8000, 4'd15, 1'b1);
    step(16'h8001);
    step(16'h0001); chk_out("rr2", 16'h0001, 4'd0, 1'b1);
    step(16'h8001);
    step(16'h8000); chk_out("rr3", 16'h8000, 4'd15, 1'b1);
    step(16'h8001);
    step(16'h0001); chk_out("rr4", 16'h0001, 4'd0, 1'b1);

    // back-to-back handoff 3 -> 4 -> 10 -> 3
    pulse_reset();
    step(16'h0418); chk_out("hand3", 16'h0008, 4'd3, 1'b1);
    step(16'h0410); chk_out("hand4", 16'h0010, 4'd4, 1'b1);
    step(16'h0408); chk_out("hand10", 16'h0400, 4'd10, 1'b1);
    step(16'h0408);
    step(16'h0008); chk_out("hand3b", 16'h0008, 4'd3, 1'b1);

    // contended hold: rotates every MH cycles only with the tenure limit
    pulse_reset();
    for (int t = 0; t < 3 * MH; t++) begin
      step(16'h0003);
      if (TO && (t / MH) % 2 == 1) chk_out("hold_b", 16'h0002, 4'd1, 1'b1);
      else                         chk_out("hold_a", 16'h0001, 4'd0, 1'b1);
    end
    for (int t = 0; t < 2 * MH + 3; t++) begin
      step(16'h0001);
      chk_out("sole", 16'h0001, 4'd0, 1'b1);
    end

    // random traffic against the model
    pulse_reset();
    for (int c = 0; c < 10000; c++) begin
      r = 16'($urandom);
      if (c % 3 != 0) r = r & 16'($urandom);
      step(r);
    end

    chk("max_wait_le_15", {31'h0, (max_wait <= 15)}, 32'h1);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
